// File: rtl/mp_regfile.sv
// rtl/mp_regfile.sv - dual-write, NRD-read register file with zero-fill sweep controller.
// Define MP_REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module mp_regfile #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [AW-1:0]     WA0,
  input  logic [AW-1:0]     WA1,
  input  logic [DW-1:0]     WD0,
  input  logic [DW-1:0]     WD1,
  input  logic [NRD*AW-1:0] RA,
  output logic [NRD*DW-1:0] RD,
  output logic              Busy
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          wr0_en, wr1_en;

  // Writes are only honoured in IDLE; entry 0 is hardwired when ZERO_R0 is set.
  always_comb begin
    wr0_en = (state_q == IDLE) && WE0 && !((ZERO_R0 != 0) && (WA0 == '0));
    wr1_en = (state_q == IDLE) && WE1 && !((ZERO_R0 != 0) && (WA1 == '0));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (wr0_en) mem_d[WA0] = WD0;
        // Port 1 is applied last so it wins an address collision.
        if (wr1_en) mem_d[WA1] = WD1;
        if (Clr) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        mem_d[cnt_q] = '0;
        if (Clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // Contents are never reset directly; the post-reset sweep clears them.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign Busy = (state_q == SWEEP);

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    assign ra = RA[g*AW +: AW];

    always_comb begin
      rd = mem_q[ra];
`ifdef MP_REGFILE_BYPASS_EN
      if (wr1_en && (WA1 == ra)) begin
        rd = WD1;
      end else if (wr0_en && (WA0 == ra)) begin
        rd = WD0;
      end
`endif
      if ((state_q == SWEEP) || ((ZERO_R0 != 0) && (ra == '0))) begin
        rd = '0;
      end
    end

    assign RD[g*DW +: DW] = rd;
  end

endmodule

// File: tb/tb_mp_regfile.sv
// tb/tb_mp_regfile.sv - directed and random checks of mp_regfile against a reference model.
module tb_mp_regfile;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic              Clk = 1'b0;
  logic              Reset, Clr, WE0, WE1;
  logic [AW-1:0]     WA0, WA1;
  logic [DW-1:0]     WD0, WD1;
  logic [NRD*AW-1:0] RA;
  logic [NRD*DW-1:0] RD;
  logic              Busy;

  always #5 Clk = ~Clk;

  mp_regfile dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Clr  (Clr),
    .WE0  (WE0),
    .WE1  (WE1),
    .WA0  (WA0),
    .WA1  (WA1),
    .WD0  (WD0),
    .WD1  (WD1),
    .RA   (RA),
    .RD   (RD),
    .Busy (Busy)
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  int            sweep_left;
  int            sweep_pos;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (sweep_left > 0 || a == '0) return '0;
`ifdef MP_REGFILE_BYPASS_EN
    if (WE1 && WA1 == a && WA1 != '0) return WD1;
    if (WE0 && WA0 == a && WA0 != '0) return WD0;
`endif
    return ref_mem[a];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_edge();
    if (!Reset) begin
      sweep_left = DEPTH;
      sweep_pos  = 0;
    end else if (sweep_left > 0) begin
      if (Clr) begin
        sweep_left = DEPTH;
        sweep_pos  = 0;
      end else begin
        ref_mem[sweep_pos] = '0;
        sweep_pos++;
        sweep_left--;
      end
    end else begin
      if (WE0 && WA0 != '0) ref_mem[WA0] = WD0;
      if (WE1 && WA1 != '0) ref_mem[WA1] = WD1;
      if (Clr) begin
        sweep_left = DEPTH;
        sweep_pos  = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    logic exp_b;
    #1;
    for (int p = 0; p < NRD; p++) begin
      check({tag, "_rd"}, RD[p*DW +: DW], ref_read(RA[p*AW +: AW]));
    end
    @(posedge Clk);
    ref_edge();
    #1;
    exp_b = (sweep_left > 0);
    check({tag, "_busy"}, {31'b0, Busy}, {31'b0, exp_b});
    @(negedge Clk);
  endtask

  task automatic quiet();
    Clr = 1'b0;
    WE0 = 1'b0;
    WE1 = 1'b0;
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    Reset = 1'b0; Clr = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    WA0 = '0; WA1 = '0; WD0 = '0; WD1 = '0; RA = '0;
    sweep_left = DEPTH;
    sweep_pos  = 0;
    @(posedge Clk);
    @(negedge Clk);

    // Reset held, then released: busy for exactly DEPTH edges.
    repeat (3) tick("rst_hold");
    Reset = 1'b1;
    n = 0;
    while (Busy && n < 100) begin
      tick("rst_sweep");
      n++;
    end
    check("rst_len", 32'(n), 32'd32);
    for (int i = 0; i < DEPTH; i += 2) begin
      RA = {AW'(i + 1), AW'(i)};
      tick("zero_all");
      check("zero_const", RD, '0);
    end

    // Simple write, then entry-0 write is dropped.
    WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'hDEADBEEF; RA = {5'd0, 5'd5};
    tick("w5");
    quiet();
    tick("r5");
    check("r5_const", RD[DW-1:0], 32'hDEADBEEF);
    WE0 = 1'b1; WA0 = 5'd0; WD0 = 32'h1; RA = {5'd5, 5'd0};
    tick("w0");
    quiet();
    tick("r0");
    check("r0_const", RD[DW-1:0], 32'h0);

    // Write collision: port 1 wins.
    WE0 = 1'b1; WE1 = 1'b1; WA0 = 5'd7; WA1 = 5'd7; WD0 = 32'h11; WD1 = 32'h22;
    tick("coll");
    quiet();
    RA = {5'd7, 5'd7};
    tick("coll_rd");
    check("coll_const", RD, {32'h22, 32'h22});

    // Same-cycle read of an entry being written.
    WE1 = 1'b1; WA1 = 5'd9; WD1 = 32'hA5A5A5A5; RA = {5'd9, 5'd0};
    #1;
`ifdef MP_REGFILE_BYPASS_EN
    check("byp_same", RD[2*DW-1:DW], 32'hA5A5A5A5);
`else
    check("byp_same", RD[2*DW-1:DW], 32'h0);
`endif
    tick("byp");
    quiet();
    tick("byp_after");
    check("byp_after_const", RD[2*DW-1:DW], 32'hA5A5A5A5);

    // Fill, then Clr with a second Clr in the 10th sweep cycle.
    for (int i = 1; i < DEPTH; i++) begin
      WE0 = 1'b1; WA0 = AW'(i); WD0 = $urandom; RA = NRD*AW'($urandom);
      tick("fill");
    end
    quiet();
    Clr = 1'b1;
    tick("clr");
    n = 0;
    while (Busy && n < 200) begin
      Clr = (n == 9);
      WE1 = 1'b1; WA1 = AW'($urandom); WD1 = $urandom; RA = NRD*AW'($urandom);
      tick("clr_sweep");
      n++;
    end
    quiet();
    check("clr_len", 32'(n), 32'd42);
    for (int i = 0; i < DEPTH; i += 2) begin
      RA = {AW'(i + 1), AW'(i)};
      tick("clr_zero");
      check("clr_zero_const", RD, '0);
    end

    // Reset pulse in the 20th sweep cycle restarts the sweep.
    Clr = 1'b1;
    tick("clr2");
    Clr = 1'b0;
    repeat (19) tick("pre_rst");
    Reset = 1'b0;
    tick("mid_rst");
    Reset = 1'b1;
    n = 0;
    while (Busy && n < 100) begin
      tick("post_rst");
      n++;
    end
    check("mid_rst_len", 32'(n), 32'd32);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      WE0 = 1'($urandom); WE1 = 1'($urandom);
      WA0 = AW'($urandom); WA1 = ($urandom_range(0, 3) == 0) ? WA0 : AW'($urandom);
      WD0 = $urandom; WD1 = $urandom;
      for (int p = 0; p < NRD; p++) begin
        case ($urandom_range(0, 3))
          0:       a = WA0;
          1:       a = WA1;
          default: a = AW'($urandom);
        endcase
        RA[p*AW +: AW] = a;
      end
      Clr   = ($urandom_range(0, 63) == 0);
      Reset = ($urandom_range(0, 127) != 0);
      tick("rand");
    end
    quiet();
    Reset = 1'b1;
    n = 0;
    while (Busy && n < 100) begin
      tick("drain");
      n++;
    end
    check("drain_idle", {31'b0, Busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
